// File: rtl/layer6_pkg.sv
// Shared definitions for the layer-5 result reader: scan geometry, address
// width and the sequencer state encoding.
`ifndef LAYER6_WEIGHT_INPUT_LENGTH
`define LAYER6_WEIGHT_INPUT_LENGTH 16
`endif

package layer6_pkg;

    localparam int unsigned LAYER5_DIM = 5;
    localparam int unsigned ADDR_W     = 16;
    // Row/col indices never exceed 7 (DIM is at most 8).
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } reader_state_t;

endpackage

// File: rtl/layer5_result_reader_if.sv
// Buffer read port plus the valid/ready word stream towards layer 6.
// master = reader side, slave = buffer/consumer side.
interface layer5_result_reader_if
    import layer6_pkg::*;
#(
    parameter int unsigned WORD_W = `LAYER6_WEIGHT_INPUT_LENGTH
);

    logic [ADDR_W-1:0] read_row_addr;
    logic [ADDR_W-1:0] read_col_addr;
    logic              layer5_result_read_signal;
    logic [WORD_W-1:0] layer5_result_output;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output read_row_addr,
        output read_col_addr,
        output layer5_result_read_signal,
        input  layer5_result_output,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  read_row_addr,
        input  read_col_addr,
        input  layer5_result_read_signal,
        output layer5_result_output,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/layer5_scan_counter.sv
// Row-major row/col counter for the DIM x DIM raster scan.
// wrap_last flags the final cell; advancing from it wraps to (0,0).
module layer5_scan_counter
    import layer6_pkg::*;
#(
    parameter int unsigned DIM = LAYER5_DIM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             wrap_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    assign wrap_last = (row == LAST_IDX) && (col == LAST_IDX);

    // Step one cell per advance, column fastest, wrapping at the end of the grid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer5_result_reader.sv
// Read-side sequencer for the layer-5 result buffer: raster-scans DIM x DIM
// words and streams them to layer 6 over valid/ready with a last marker.
// Optional feature macro: LAYER5_READER_REPEAT_EN (adds repeat_count, runs
// repeat_count+1 back-to-back passes).
module layer5_result_reader
    import layer6_pkg::*;
#(
    parameter int unsigned WORD_W = `LAYER6_WEIGHT_INPUT_LENGTH,
    parameter int unsigned DIM    = LAYER5_DIM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef LAYER5_READER_REPEAT_EN
    input  logic [7:0]             repeat_count,
`endif
    layer5_result_reader_if.master bus,
    output logic                   busy,
    output logic                   done
);

    reader_state_t     state;
    logic [WORD_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;
    logic              rd_strobe;
    logic              final_pass;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              wrap_last;

    // A read is issued whenever the output register can take a new word this edge.
    assign rd_strobe = (state == READ) && (!valid_q || bus.out_ready);

    assign bus.layer5_result_read_signal = rd_strobe;
    assign bus.read_row_addr             = rd_strobe ? ADDR_W'(row) : '0;
    assign bus.read_col_addr             = rd_strobe ? ADDR_W'(col) : '0;
    assign bus.out_data                  = data_q;
    assign bus.out_valid                 = valid_q;
    assign bus.out_last                  = last_q;

    layer5_scan_counter #(
        .DIM (DIM)
    ) u_scan_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .advance   (rd_strobe),
        .row       (row),
        .col       (col),
        .wrap_last (wrap_last)
    );

`ifdef LAYER5_READER_REPEAT_EN
    logic [7:0] pass_cnt;
    logic [7:0] pass_target;

    assign final_pass = (pass_cnt == pass_target);

    // Count completed passes; the target is latched together with start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt    <= '0;
            pass_target <= '0;
        end else if (state == IDLE) begin
            pass_cnt <= '0;
            if (start) begin
                pass_target <= repeat_count;
            end
        end else if (rd_strobe && wrap_last && !final_pass) begin
            pass_cnt <= pass_cnt + 8'd1;
        end
    end
`else
    assign final_pass = 1'b1;
`endif

    // Sequencer with registered stream, busy and done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    // Stalled (valid and not ready) means no strobe, so the register holds.
                    if (rd_strobe) begin
                        data_q  <= bus.layer5_result_output;
                        valid_q <= 1'b1;
                        last_q  <= wrap_last && final_pass;
                        if (wrap_last && final_pass) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer5_result_reader.sv
// Self-checking bench for layer5_result_reader: scoreboard of expected words
// built from the buffer contents, per-cycle stream/address/busy checks, and
// scan timing checks. Repeat tests run only with LAYER5_READER_REPEAT_EN.
module tb_layer5_result_reader;

    localparam int unsigned W = 16;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef LAYER5_READER_REPEAT_EN
    logic [7:0] repeat_count = '0;
`endif

    always #5 clk = ~clk;

    layer5_result_reader_if #(.WORD_W(W)) bus ();

    layer5_result_reader #(
        .WORD_W (W),
        .DIM    (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef LAYER5_READER_REPEAT_EN
        .repeat_count (repeat_count),
`endif
        .bus          (bus.master),
        .busy         (busy),
        .done         (done)
    );

    logic [W-1:0] mem [8][8];
    assign bus.layer5_result_output = mem[bus.read_row_addr[2:0]][bus.read_col_addr[2:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    logic [W-1:0] expq[$];
    logic [W-1:0] got[$];
    bit scan_active = 0;
    bit scan_done = 0;
    int n_hs = 0;
    int first_rel = -1;
    int last_rel = -1;
    int done_rel = -1;
    int done_cnt = 0;
    int rd_idx = 0;
    bit prev_hold = 0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Per-cycle compare process against the scoreboard and scan-level model.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_hold = 0;
        end else begin
            chk("addr_high_bits", {bus.read_row_addr[15:3], bus.read_col_addr[15:3]}, 0);
            if (bus.layer5_result_read_signal) begin
                chk("rd_row", bus.read_row_addr, (rd_idx % (D * D)) / D);
                chk("rd_col", bus.read_col_addr, rd_idx % D);
                rd_idx++;
            end else begin
                chk("addr_idle_zero", {bus.read_row_addr, bus.read_col_addr}, 0);
            end
            if (prev_hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            chk("busy", busy, scan_active && !done);
            if (bus.out_valid && bus.out_ready) begin
                chk("word_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    logic [W-1:0] e;
                    e = expq.pop_front();
                    chk("out_data", bus.out_data, e);
                    chk("out_last", bus.out_last, expq.size() == 0);
                end
                got.push_back(bus.out_data);
                n_hs++;
                if (n_hs == 1) first_rel = cyc - e0;
                last_rel = cyc - e0;
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - e0;
                chk("done_all_drained", expq.size(), 0);
                scan_active = 0;
                scan_done = 1;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_strobe"}, bus.layer5_result_read_signal, 0);
        chk({tag, "_addr"}, {bus.read_row_addr, bus.read_col_addr}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode: 0 ready high, 1 three-cycle stall on word 9, 2 random ready,
    //       3 extra start mid-scan, 4 reset after 10 words
    task automatic run_scan(input int mode, input int reps, input int stall);
        int stall_left;
        bit stalled;
        int words;
        expq.delete();
        got.delete();
        n_hs = 0;
        done_cnt = 0;
        rd_idx = 0;
        scan_done = 0;
        first_rel = -1;
        last_rel = -1;
        done_rel = -1;
        for (int p = 0; p <= reps; p++)
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++)
                    expq.push_back(mem[r][c]);
        words = expq.size();
`ifdef LAYER5_READER_REPEAT_EN
        repeat_count = reps[7:0];
`endif
        @(posedge clk);
        #1 start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        e0 = cyc;
        scan_active = 1;
        #1 start = 1'b0;
        stall_left = 0;
        stalled = 0;
        for (int i = 0; i < 2000 && !scan_done; i++) begin
            case (mode)
                1: begin
                    if (stall_left > 0) begin
                        chk("stall_data_9", bus.out_data, 9);
                        stall_left--;
                        bus.out_ready = 1'b0;
                    end else if (!stalled && bus.out_valid && bus.out_data == 9) begin
                        stalled = 1;
                        stall_left = 2;
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                2: bus.out_ready = 1'($urandom_range(0, 1));
                3: begin
                    bus.out_ready = 1'b1;
                    start = (i == 8);
                end
                4: bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b1;
            endcase
            if (mode == 4 && n_hs >= 10) begin
                rst = 1'b0;
                #1;
                check_outputs_zero("reset_mid_scan");
                scan_active = 0;
                expq.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (mode != 4) begin
            chk("scan_finished", scan_done, 1);
            chk("word_count", n_hs, words);
            if (mode != 2) begin
                chk("first_hs_cycle", first_rel, 2);
                chk("last_hs_cycle", last_rel, 1 + words + stall);
                chk("done_cycle", done_rel, 2 + words + stall);
            end
            repeat (2) @(posedge clk);
            #1;
            chk("single_done", done_cnt, 1);
            chk("idle_after_done", {busy, done, bus.out_valid}, 0);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[r][c] = W'(r * 8 + c);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;

        run_scan(0, 0, 0);
        chk("pin_word0", got[0], 0);
        chk("pin_word5", got[5], 8);
        chk("pin_word24", got[24], 36);

        run_scan(1, 0, 3);
        chk("pin_stall_word", got[6], 9);
        chk("pin_after_stall", got[7], 10);

        run_scan(3, 0, 0);

        run_scan(4, 0, 0);
        run_scan(0, 0, 0);
        chk("pin_restart_word0", got[0], 0);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[r][c] = W'($urandom);
        run_scan(2, 0, 0);
        run_scan(2, 0, 0);

`ifdef LAYER5_READER_REPEAT_EN
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[r][c] = W'(r * 8 + c);
        run_scan(0, 2, 0);
        chk("pin_rep_word25", got[25], 0);
        chk("pin_rep_word74", got[74], 36);
        run_scan(2, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
